// File: rtl/eic_irq_scheduler_pkg.sv
// rtl/eic_irq_scheduler_pkg.sv - shared types, constants and priority encoder for the EIC scheduler
//
// Purpose: FSM state encoding, level width, the "nothing offered" level and
// the 64-input priority encoder used for candidate selection.
package eic_irq_scheduler_pkg;

  localparam int LEVEL_W = 8;
  localparam logic [LEVEL_W-1:0] EIC_NONE = 8'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OFFER = 2'd1,
    S_CLEAR = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic       found;
    logic [5:0] idx;
  } prio_t;

  // Highest set index wins; higher channel index means higher priority.
  function automatic prio_t prio_enc64(input logic [63:0] req);
    prio_t r;
    r.found = 1'b0;
    r.idx   = '0;
    for (int i = 0; i < 64; i++) begin
      if (req[i]) begin
        r.found = 1'b1;
        r.idx   = 6'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/eic_isr_stack.sv
// rtl/eic_isr_stack.sv - LIFO of in-service interrupt levels
//
// Purpose: tracks nested in-service levels; top is registered.
// Ports:
//   CLK, RESET      clock, synchronous active-high reset
//   push, push_level push a level (ignored when full unless popping too)
//   pop             pop the top (ignored when empty)
//   top             current top level, 0 when empty
//   count           number of entries in use
module eic_isr_stack
  import eic_irq_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               push,
  input  logic [LEVEL_W-1:0] push_level,
  input  logic               pop,
  output logic [LEVEL_W-1:0] top,
  output logic [3:0]         count
);

  // Storage is sized for the largest legal depth so a 3-bit index always fits.
  logic [LEVEL_W-1:0] mem [0:7];
  logic [2:0] top_idx;
  logic [2:0] nxt_idx;
  logic [2:0] below_idx;
  logic       do_push;
  logic       do_pop;

  assign top_idx   = count[2:0] - 3'd1;
  assign nxt_idx   = count[2:0];
  assign below_idx = count[2:0] - 3'd2;
  assign do_pop    = pop && (count != 4'd0);
  assign do_push   = push && (do_pop || (count < 4'(DEPTH)));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= 4'd0;
      top   <= EIC_NONE;
    end else if (do_pop && do_push) begin
      // Pop then push: the new level replaces the old top in place.
      mem[top_idx] <= push_level;
      top          <= push_level;
    end else if (do_push) begin
      mem[nxt_idx] <= push_level;
      top          <= push_level;
      count        <= count + 4'd1;
    end else if (do_pop) begin
      count <= count - 4'd1;
      top   <= (count > 4'd1) ? mem[below_idx] : EIC_NONE;
    end
  end

endmodule

// File: rtl/eic_irq_scheduler.sv
// rtl/eic_irq_scheduler.sv - delivers pending interrupt flags to the MIPS EIC CPU interface
//
// Purpose: offers the highest pending channel above the in-service level,
// clears its flag on acknowledge and tracks nesting until EOI.
// Ports:
//   CLK, RESET          clock, synchronous active-high reset
//   pending             masked EIFR flags
//   cpu_iack, eoi       CPU acknowledge pulse, end-of-interrupt pulse
//   clr_mask            one-hot flag clear pulse
//   EIC_Interrupt       offered level (channel+1), 0 = none
//   EIC_Vector          EIC_Interrupt[5:0]
//   EIC_Offset          constant 0
//   EIC_ShadowSet       constant 0
//   isr_level           top of in-service stack
//   isr_count           in-service stack depth
//   spurious_iack       sticky: acknowledge outside an offer
//   eoi_underflow       sticky: EOI with empty stack
module eic_irq_scheduler
  import eic_irq_scheduler_pkg::*;
#(
  parameter int CHANNELS    = 64,
  parameter int STACK_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [CHANNELS-1:0] pending,
  input  logic                cpu_iack,
  input  logic                eoi,
  output logic [CHANNELS-1:0] clr_mask,
  output logic [7:0]          EIC_Interrupt,
  output logic [5:0]          EIC_Vector,
  output logic [16:0]         EIC_Offset,
  output logic [3:0]          EIC_ShadowSet,
  output logic [7:0]          isr_level,
  output logic [3:0]          isr_count,
  output logic                spurious_iack,
  output logic                eoi_underflow
);

  localparam logic [63:0] ONE64 = 64'd1;

  sched_state_t state;
  logic [5:0]   off_idx;
  logic [63:0]  pend64;
  logic [63:0]  elig;
  prio_t        cand;
  logic         cand_valid;
  logic [7:0]   cand_level;
  logic         push;

  assign pend64 = 64'(pending);

  // Level-compare mask ahead of the priority encoder: only channels whose
  // level exceeds the in-service level may interrupt.
  always_comb begin
    elig = '0;
    for (int i = 0; i < 64; i++) begin
      elig[i] = pend64[i] && (8'(i + 1) > isr_level);
    end
  end

  assign cand       = prio_enc64(elig);
  assign cand_valid = cand.found && (isr_count != 4'(STACK_DEPTH));
  assign cand_level = {2'b00, cand.idx} + 8'd1;
  assign push       = (state == S_OFFER) && cpu_iack;

  eic_isr_stack #(
    .DEPTH(STACK_DEPTH)
  ) u_stack (
    .CLK        (CLK),
    .RESET      (RESET),
    .push       (push),
    .push_level (EIC_Interrupt),
    .pop        (eoi),
    .top        (isr_level),
    .count      (isr_count)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= S_IDLE;
      off_idx       <= '0;
      EIC_Interrupt <= EIC_NONE;
      clr_mask      <= '0;
      spurious_iack <= 1'b0;
      eoi_underflow <= 1'b0;
    end else begin
      clr_mask <= '0;
      if (eoi && (isr_count == 4'd0)) eoi_underflow <= 1'b1;
      case (state)
        S_IDLE: begin
          if (cpu_iack) spurious_iack <= 1'b1;
          if (cand_valid) begin
            state         <= S_OFFER;
            off_idx       <= cand.idx;
            EIC_Interrupt <= cand_level;
          end
        end
        S_OFFER: begin
          if (cpu_iack) begin
            // Acknowledge wins over any same-cycle retarget or withdrawal.
            clr_mask      <= CHANNELS'(ONE64 << off_idx);
            EIC_Interrupt <= EIC_NONE;
            state         <= S_CLEAR;
          end else if (!cand_valid) begin
            EIC_Interrupt <= EIC_NONE;
            state         <= S_IDLE;
          end else if (cand.idx != off_idx) begin
            off_idx       <= cand.idx;
            EIC_Interrupt <= cand_level;
          end
        end
        S_CLEAR: begin
          // One dead cycle lets the flag register drop before re-evaluation.
          if (cpu_iack) spurious_iack <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign EIC_Vector    = EIC_Interrupt[5:0];
  assign EIC_Offset    = 17'd0;
  assign EIC_ShadowSet = 4'd0;

endmodule

// File: tb/tb_eic_irq_scheduler.sv
// tb/tb_eic_irq_scheduler.sv - self-checking bench for eic_irq_scheduler
module tb_eic_irq_scheduler;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [63:0] pending = '0;
  logic        cpu_iack = 1'b0;
  logic        eoi = 1'b0;
  logic [63:0] clr_mask;
  logic [7:0]  EIC_Interrupt;
  logic [5:0]  EIC_Vector;
  logic [16:0] EIC_Offset;
  logic [3:0]  EIC_ShadowSet;
  logic [7:0]  isr_level;
  logic [3:0]  isr_count;
  logic        spurious_iack;
  logic        eoi_underflow;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_clr_q [$];
  logic [7:0]  exp_lvl_q [$];
  logic [7:0]  exp_off_q [$];
  logic [63:0] e_clr;
  logic [7:0]  e_lvl;
  logic [7:0]  e_off;

  eic_irq_scheduler #(.CHANNELS(64), .STACK_DEPTH(4)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .pending       (pending),
    .cpu_iack      (cpu_iack),
    .eoi           (eoi),
    .clr_mask      (clr_mask),
    .EIC_Interrupt (EIC_Interrupt),
    .EIC_Vector    (EIC_Vector),
    .EIC_Offset    (EIC_Offset),
    .EIC_ShadowSet (EIC_ShadowSet),
    .isr_level     (isr_level),
    .isr_count     (isr_count),
    .spurious_iack (spurious_iack),
    .eoi_underflow (eoi_underflow)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Raise a flag and queue the level the scheduler should offer for it.
  task automatic raise(input int ch, input logic [7:0] expect_off);
    pending[ch] = 1'b1;
    exp_off_q.push_back(expect_off);
  endtask

  // Acknowledge the current offer; queue the clear pulse and new top level.
  task automatic drive_iack(input int ch, input logic [7:0] top_after, input bit with_eoi);
    exp_clr_q.push_back(64'd1 << ch);
    exp_lvl_q.push_back(top_after);
    cpu_iack = 1'b1;
    eoi = with_eoi;
    tick();
    cpu_iack = 1'b0;
    eoi = 1'b0;
  endtask

  // Flag register drops one cycle after the clear pulse.
  task automatic flag_clear(input int ch);
    tick();
    pending[ch] = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (3) tick();
    checks++; if ({EIC_Interrupt, EIC_Vector, EIC_Offset, EIC_ShadowSet} !== '0) begin errors++; $display("FAIL reset_eic: got %0h expected 0", {EIC_Interrupt, EIC_Vector, EIC_Offset, EIC_ShadowSet}); end
    checks++; if ({isr_level, isr_count, spurious_iack, eoi_underflow} !== '0) begin errors++; $display("FAIL reset_stack: got %0h expected 0", {isr_level, isr_count, spurious_iack, eoi_underflow}); end
    checks++; if (clr_mask !== '0) begin errors++; $display("FAIL reset_clr: got %0h expected 0", clr_mask); end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_basic_offer();
    raise(5, 8'd6);
    tick();
    e_off = exp_off_q.pop_front();
    checks++; if (EIC_Interrupt !== e_off) begin errors++; $display("FAIL basic_offer: got %0d expected %0d", EIC_Interrupt, e_off); end
    checks++; if (EIC_Vector !== e_off[5:0]) begin errors++; $display("FAIL basic_vector: got %0d expected %0d", EIC_Vector, e_off[5:0]); end
    drive_iack(5, 8'd6, 1'b0);
    e_clr = exp_clr_q.pop_front(); e_lvl = exp_lvl_q.pop_front();
    checks++; if ({clr_mask, isr_level} !== {e_clr, e_lvl}) begin errors++; $display("FAIL basic_ack: got clr=%0h lvl=%0d expected clr=%0h lvl=%0d", clr_mask, isr_level, e_clr, e_lvl); end
    checks++; if ({isr_count, EIC_Interrupt} !== {4'd1, 8'd0}) begin errors++; $display("FAIL basic_count: got cnt=%0d int=%0d expected cnt=1 int=0", isr_count, EIC_Interrupt); end
    flag_clear(5);
    checks++; if (clr_mask !== '0) begin errors++; $display("FAIL basic_clr_pulse: got %0h expected 0", clr_mask); end
  endtask

  task automatic test_level_block();
    pending[3] = 1'b1;
    repeat (3) tick();
    checks++; if (EIC_Interrupt !== 8'd0) begin errors++; $display("FAIL block_no_offer: got %0d expected 0", EIC_Interrupt); end
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++; if ({isr_level, isr_count, EIC_Interrupt} !== {8'd0, 4'd0, 8'd0}) begin errors++; $display("FAIL block_eoi: got lvl=%0d cnt=%0d int=%0d expected 0 0 0", isr_level, isr_count, EIC_Interrupt); end
    exp_off_q.push_back(8'd4);
    tick();
    e_off = exp_off_q.pop_front();
    checks++; if ({EIC_Interrupt, EIC_Vector} !== {e_off, e_off[5:0]}) begin errors++; $display("FAIL block_offer: got %0d expected %0d", EIC_Interrupt, e_off); end
  endtask

  task automatic test_preempt();
    raise(40, 8'd41);
    tick();
    e_off = exp_off_q.pop_front();
    checks++; if (EIC_Interrupt !== e_off) begin errors++; $display("FAIL preempt_retarget: got %0d expected %0d", EIC_Interrupt, e_off); end
    drive_iack(40, 8'd41, 1'b0);
    e_clr = exp_clr_q.pop_front(); e_lvl = exp_lvl_q.pop_front();
    checks++; if ({clr_mask, isr_level} !== {e_clr, e_lvl}) begin errors++; $display("FAIL preempt_ack: got clr=%0h lvl=%0d expected clr=%0h lvl=%0d", clr_mask, isr_level, e_clr, e_lvl); end
    flag_clear(40);
    pending[3] = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0;
    tick();
    checks++; if ({isr_count, EIC_Interrupt} !== {4'd0, 8'd0}) begin errors++; $display("FAIL preempt_cleanup: got cnt=%0d int=%0d expected 0 0", isr_count, EIC_Interrupt); end
  endtask

  task automatic test_nesting();
    int chans [4] = '{1, 9, 19, 29};
    foreach (chans[k]) begin
      raise(chans[k], 8'(chans[k] + 1));
      tick();
      e_off = exp_off_q.pop_front();
      checks++; if (EIC_Interrupt !== e_off) begin errors++; $display("FAIL nest_offer%0d: got %0d expected %0d", k, EIC_Interrupt, e_off); end
      drive_iack(chans[k], 8'(chans[k] + 1), 1'b0);
      e_clr = exp_clr_q.pop_front(); e_lvl = exp_lvl_q.pop_front();
      checks++; if ({clr_mask, isr_level} !== {e_clr, e_lvl}) begin errors++; $display("FAIL nest_ack%0d: got clr=%0h lvl=%0d expected clr=%0h lvl=%0d", k, clr_mask, isr_level, e_clr, e_lvl); end
      flag_clear(chans[k]);
    end
    checks++; if ({isr_count, isr_level} !== {4'd4, 8'd30}) begin errors++; $display("FAIL nest_full: got cnt=%0d lvl=%0d expected 4 30", isr_count, isr_level); end
    pending[50] = 1'b1;
    repeat (3) tick();
    checks++; if (EIC_Interrupt !== 8'd0) begin errors++; $display("FAIL nest_blocked: got %0d expected 0", EIC_Interrupt); end
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++; if ({isr_count, isr_level} !== {4'd3, 8'd20}) begin errors++; $display("FAIL nest_pop: got cnt=%0d lvl=%0d expected 3 20", isr_count, isr_level); end
    exp_off_q.push_back(8'd51);
    tick();
    e_off = exp_off_q.pop_front();
    checks++; if (EIC_Interrupt !== e_off) begin errors++; $display("FAIL nest_offer51: got %0d expected %0d", EIC_Interrupt, e_off); end
    drive_iack(50, 8'd51, 1'b0);
    e_clr = exp_clr_q.pop_front(); e_lvl = exp_lvl_q.pop_front();
    checks++; if ({clr_mask, isr_level, isr_count} !== {e_clr, e_lvl, 4'd4}) begin errors++; $display("FAIL nest_ack51: got clr=%0h lvl=%0d cnt=%0d expected clr=%0h lvl=%0d cnt=4", clr_mask, isr_level, isr_count, e_clr, e_lvl); end
    flag_clear(50);
    eoi = 1'b1; repeat (4) tick(); eoi = 1'b0;
    checks++; if ({isr_count, isr_level} !== {4'd0, 8'd0}) begin errors++; $display("FAIL nest_drain: got cnt=%0d lvl=%0d expected 0 0", isr_count, isr_level); end
  endtask

  task automatic test_back_to_back();
    raise(2, 8'd3);
    tick();
    e_off = exp_off_q.pop_front();
    checks++; if (EIC_Interrupt !== e_off) begin errors++; $display("FAIL b2b_offer3: got %0d expected %0d", EIC_Interrupt, e_off); end
    drive_iack(2, 8'd3, 1'b0);
    e_clr = exp_clr_q.pop_front(); e_lvl = exp_lvl_q.pop_front();
    checks++; if ({clr_mask, isr_level} !== {e_clr, e_lvl}) begin errors++; $display("FAIL b2b_ack3: got clr=%0h lvl=%0d expected clr=%0h lvl=%0d", clr_mask, isr_level, e_clr, e_lvl); end
    flag_clear(2);
    raise(20, 8'd21);
    tick();
    e_off = exp_off_q.pop_front();
    checks++; if (EIC_Interrupt !== e_off) begin errors++; $display("FAIL b2b_offer21: got %0d expected %0d", EIC_Interrupt, e_off); end
    // Acknowledge, EOI and a higher request all land on the same edge.
    pending[30] = 1'b1;
    drive_iack(20, 8'd21, 1'b1);
    e_clr = exp_clr_q.pop_front(); e_lvl = exp_lvl_q.pop_front();
    checks++; if ({clr_mask, isr_level, isr_count} !== {e_clr, e_lvl, 4'd1}) begin errors++; $display("FAIL b2b_pop_push: got clr=%0h lvl=%0d cnt=%0d expected clr=%0h lvl=%0d cnt=1", clr_mask, isr_level, isr_count, e_clr, e_lvl); end
    flag_clear(20);
    exp_off_q.push_back(8'd31);
    tick();
    e_off = exp_off_q.pop_front();
    checks++; if (EIC_Interrupt !== e_off) begin errors++; $display("FAIL b2b_offer31: got %0d expected %0d", EIC_Interrupt, e_off); end
    pending[30] = 1'b0;
    tick();
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++; if ({isr_count, EIC_Interrupt} !== {4'd0, 8'd0}) begin errors++; $display("FAIL b2b_cleanup: got cnt=%0d int=%0d expected 0 0", isr_count, EIC_Interrupt); end
  endtask

  task automatic test_withdraw();
    raise(12, 8'd13);
    tick();
    e_off = exp_off_q.pop_front();
    checks++; if (EIC_Interrupt !== e_off) begin errors++; $display("FAIL withdraw_offer: got %0d expected %0d", EIC_Interrupt, e_off); end
    pending[12] = 1'b0;
    tick();
    checks++; if ({EIC_Interrupt, clr_mask} !== {8'd0, 64'd0}) begin errors++; $display("FAIL withdraw_drop: got int=%0d clr=%0h expected 0 0", EIC_Interrupt, clr_mask); end
    checks++; if (spurious_iack !== 1'b0) begin errors++; $display("FAIL withdraw_pre_spurious: got %0b expected 0", spurious_iack); end
    cpu_iack = 1'b1; tick(); cpu_iack = 1'b0;
    checks++; if ({spurious_iack, clr_mask, isr_count} !== {1'b1, 64'd0, 4'd0}) begin errors++; $display("FAIL withdraw_late_iack: got sp=%0b clr=%0h cnt=%0d expected 1 0 0", spurious_iack, clr_mask, isr_count); end
    tick();
    checks++; if (spurious_iack !== 1'b1) begin errors++; $display("FAIL withdraw_sticky: got %0b expected 1", spurious_iack); end
  endtask

  task automatic test_underflow_reset();
    checks++; if (eoi_underflow !== 1'b0) begin errors++; $display("FAIL uf_pre: got %0b expected 0", eoi_underflow); end
    eoi = 1'b1; tick(); eoi = 1'b0;
    checks++; if ({eoi_underflow, isr_count} !== {1'b1, 4'd0}) begin errors++; $display("FAIL uf_set: got uf=%0b cnt=%0d expected 1 0", eoi_underflow, isr_count); end
    raise(7, 8'd8);
    tick();
    e_off = exp_off_q.pop_front();
    checks++; if (EIC_Interrupt !== e_off) begin errors++; $display("FAIL rst_offer: got %0d expected %0d", EIC_Interrupt, e_off); end
    RESET = 1'b1; cpu_iack = 1'b1;
    tick();
    checks++; if ({EIC_Interrupt, clr_mask, isr_level, isr_count, spurious_iack, eoi_underflow} !== '0) begin errors++; $display("FAIL rst_abort: got int=%0d clr=%0h lvl=%0d cnt=%0d sp=%0b uf=%0b expected all 0", EIC_Interrupt, clr_mask, isr_level, isr_count, spurious_iack, eoi_underflow); end
    RESET = 1'b0; cpu_iack = 1'b0; pending = '0;
    tick();
    checks++; if ({clr_mask, spurious_iack, EIC_Interrupt} !== '0) begin errors++; $display("FAIL rst_after: got clr=%0h sp=%0b int=%0d expected 0 0 0", clr_mask, spurious_iack, EIC_Interrupt); end
  endtask

  initial begin
    test_reset();
    test_basic_offer();
    test_level_block();
    test_preempt();
    test_nesting();
    test_back_to_back();
    test_withdraw();
    test_underflow_reset();
    checks++; if (exp_off_q.size() + exp_clr_q.size() + exp_lvl_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left expected 0", exp_off_q.size() + exp_clr_q.size() + exp_lvl_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
